// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the pwm_meter slice.
package pwm_meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // All-ones value of a counter of the given width (saturation ceiling).
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_meter_if.sv
// Result channel of pwm_meter: period/high data with valid/ready handshake.
interface pwm_meter_if import pwm_meter_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             meas_ready;

  modport master (output meas_period, meas_high, meas_valid, input meas_ready);
  modport slave  (input meas_period, meas_high, meas_valid, output meas_ready);
endinterface

// File: rtl/pwm_meter_sync.sv
// Input synchronizer and edge detector for the pwm_meter pulse input.
module pwm_meter_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic hw_clk,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  // Synchronizer and delay flop keep tracking the input through reset, so a
  // reset never fabricates an edge while the input is already high.
  always_ff @(posedge hw_clk) begin
    chain <= {chain[SYNC_STAGES-2:0], sig_in};
    s_d   <= s;
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
endmodule

// File: rtl/pwm_meter.sv
// Pulse period / high-time meter with a valid/ready result register.
// Optional feature: define PWM_METER_TIMEOUT_EN to flag and abandon a
// measurement whose period counter saturates (stuck output).
module pwm_meter import pwm_meter_pkg::*; #(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        hw_clk,
  input  logic        reset,
  input  logic        sig_in,
  pwm_meter_if.master meas,
  output logic        overrun,
  output logic        stuck
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  logic             s, rise, fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_p, cnt_h, cnt_p_nxt, cnt_h_nxt;
  logic             complete;
  logic             handshake;

  pwm_meter_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .hw_clk (hw_clk),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign handshake = meas.meas_valid & meas.meas_ready;

`ifdef PWM_METER_TIMEOUT_EN
  logic timeout;
`endif

  // Next-state and counter update for the IDLE/HIGH/LOW measurement FSM.
  always_comb begin
    state_nxt = state;
    cnt_p_nxt = cnt_p;
    cnt_h_nxt = cnt_h;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          cnt_p_nxt = ONE;
          cnt_h_nxt = ONE;
        end
      end
      HIGH: begin
        cnt_p_nxt = sat_inc(cnt_p);
        // s is low only on the fall cycle, so the high count freezes there.
        if (s) cnt_h_nxt = sat_inc(cnt_h);
        if (fall) state_nxt = LOW;
      end
      LOW: begin
        if (rise) begin
          complete  = 1'b1;
          state_nxt = HIGH;
          cnt_p_nxt = ONE;
          cnt_h_nxt = ONE;
        end else begin
          cnt_p_nxt = sat_inc(cnt_p);
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PWM_METER_TIMEOUT_EN
    timeout = 1'b0;
    if (state != IDLE && !complete && cnt_p == CNT_MAX) begin
      timeout   = 1'b1;
      state_nxt = IDLE;
    end
`endif
  end

  // FSM and counter registers.
  always_ff @(posedge hw_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt_p <= '0;
      cnt_h <= '0;
    end else begin
      state <= state_nxt;
      cnt_p <= cnt_p_nxt;
      cnt_h <= cnt_h_nxt;
    end
  end

  // Result register: load when empty or being drained, otherwise drop and flag.
  always_ff @(posedge hw_clk) begin
    if (reset) begin
      meas.meas_period <= '0;
      meas.meas_high   <= '0;
      meas.meas_valid  <= 1'b0;
      overrun          <= 1'b0;
    end else if (complete) begin
      if (!meas.meas_valid || handshake) begin
        meas.meas_period <= cnt_p;
        meas.meas_high   <= cnt_h;
        meas.meas_valid  <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (handshake) begin
      meas.meas_valid <= 1'b0;
    end
  end

`ifdef PWM_METER_TIMEOUT_EN
  // Stuck flag: set on saturation timeout, cleared by the next rising edge.
  always_ff @(posedge hw_clk) begin
    if (reset)        stuck <= 1'b0;
    else if (timeout) stuck <= 1'b1;
    else if (rise)    stuck <= 1'b0;
  end
`else
  assign stuck = 1'b0;
`endif
endmodule

// File: doc/pwm_meter.md
# pwm_meter

Receive-side measurement block for the iCE40 UP5K LED/test-signal path. It samples one asynchronous pulse input, such as a divided-counter test output or an externally generated PWM, on the internal fabric clock. It reports the input's period and high time, in clock cycles, through a valid/ready output register. It is the reading end of the PWM and divided-clock signals the fabric already produces, and is used for loopback checks and board bring-up.

## Interface
- CNT_W, 24, width of the period/high counters and results
- SYNC_STAGES, 2, input synchronizer flops (legal ≥ 2)
- hw_clk  in  1  fabric clock (HFOSC-derived); all logic on rising edge
- reset  in  1  synchronous, active-high
- sig_in  in  1  asynchronous pulse input
- meas_period  out  CNT_W  cycles between consecutive rising edges; reset 0
- meas_high  out  CNT_W  cycles input was high within that period; reset 0
- meas_valid  out  1  result held and pending; reset 0
- meas_ready  in  1  consumer accepts result when meas_valid & meas_ready
- overrun  out  1  sticky: a result was dropped; reset 0; cleared by reset only
- stuck  out  1  no rising edge within timeout (macro-dependent); reset 0

## Operation
- Input handling:
  - sig_in passes through a SYNC_STAGES flop chain to produce s.
  - s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- FSM states: IDLE, HIGH, LOW. Reset → IDLE, counters 0.
- IDLE: wait for rise. On rise → HIGH; cnt_p ← 1, cnt_h ← 1. No result is produced for the first edge.
- HIGH:
  - cnt_p and cnt_h increment each cycle.
  - fall → LOW; cnt_h freezes. cnt_h does not increment on the fall cycle.
- LOW:
  - cnt_p increments; cnt_h holds.
  - rise → result completes: candidate period = cnt_p, high = cnt_h. Then cnt_p ← 1, cnt_h ← 1, → HIGH.
- Resulting definitions:
  - meas_period = t_rise(n+1) − t_rise(n).
  - meas_high = t_fall − t_rise(n).
- Counters saturate at 2^CNT_W−1 and never wrap.
- Output register:
  - On completion with meas_valid=0: load meas_period/meas_high, set meas_valid.
  - On completion while meas_valid=1 and no handshake in that cycle: discard the new result, keep the old one, set overrun.
  - Completion in the same cycle as a handshake: load the new result, meas_valid stays 1, no overrun.
  - Handshake without completion: meas_valid ← 0. Data outputs hold their last value.
- Rise during HIGH cannot occur, because s is synchronized and edge-detected.
- Reset mid-measurement aborts the measurement. All outputs return to reset values; FSM → IDLE.

## Timing
- sig_in edge to rise/fall: SYNC_STAGES+1 cycles. The latency is identical for both edges, so measured widths are unbiased (±1 cycle jitter from async sampling).
- Completing rise to meas_valid=1: 1 cycle (registered).
- meas_ready is combinationally unused in any output path. No combinational path from input to output.
- Minimum measurable: period 2, high 1 (input held ≥ 1 cycle per level after sync).

## Configuration
- PWM_METER_TIMEOUT_EN defined:
  - When cnt_p saturates, stuck ← 1 and FSM → IDLE. No result is produced.
  - stuck clears on the next rise.
- PWM_METER_TIMEOUT_EN undefined:
  - stuck tied 0.
  - Counters saturate and the FSM waits indefinitely.
  - The eventual result reports saturated values.

## Structure
- Shared package pwm_meter_pkg holds:
  - FSM state enum (IDLE/HIGH/LOW).
  - CNT_W default and the saturation-max constant function.
- One sub-module: pwm_meter_sync, the SYNC_STAGES synchronizer plus edge detector. It outputs s, rise and fall.
- Counters, FSM and output register live in pwm_meter.

## Test plan
- Drive sig_in = bit 5 of a free-running counter on hw_clk, meas_ready=1 → after the first full period, every result is meas_period=64, meas_high=32, overrun=0.
- Input high 10, low 90 cycles repeating, meas_ready=1 → meas_period=100, meas_high=10 on each completion.
- Input period 20, meas_ready=0 for 3 periods → first result (20/10) held unchanged, overrun=1. Raise ready → one handshake, meas_valid drops, next result loads.
- Assert reset for 1 cycle mid-HIGH → meas_* = 0, meas_valid=0, overrun=0. The next rise produces no result; the first result appears after the second rise.
- CNT_W=8, PWM_METER_TIMEOUT_EN defined, sig_in held low after one rise → stuck=1 at 255 cycles after the rise, FSM in IDLE. A later 16-cycle-period input clears stuck, and the next result is 16.
- Same stimulus with the macro undefined → stuck stays 0. After edges resume, first result meas_period=255 (saturated).
